// File: rtl/cdiv_pkg.sv
// Shared constants, state encoding and chunk arithmetic for the constant-division
// datapath and its reconstruction (multiply-back) stage.
package cdiv_pkg;

    localparam int K_DIV   = 5;
    localparam int CHUNK_W = 4;
    localparam int CARRY_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns {carry, digit} of K_DIV*q_chunk + c; the largest value, 5*15+7 = 82, fits 7 bits.
    function automatic logic [CARRY_W+CHUNK_W-1:0] chunk_mac(
        input logic [CHUNK_W-1:0] q_chunk,
        input logic [CARRY_W-1:0] c
    );
        return (CARRY_W+CHUNK_W)'(K_DIV) * {{CARRY_W{1'b0}}, q_chunk}
             + {{CHUNK_W{1'b0}}, c};
    endfunction

endpackage

// File: rtl/mul5_recon_if.sv
// Valid/ready bundle for the y = 5*q + r reconstruction stage.
interface mul5_recon_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_q;
    logic [2:0]   in_r;
    logic         out_valid;
    logic         out_ready;
    logic [W+2:0] out_y;
    logic         out_err;

    modport master (
        output in_valid, in_q, in_r, out_ready,
        input  in_ready, out_valid, out_y, out_err
    );

    modport slave (
        input  in_valid, in_q, in_r, out_ready,
        output in_ready, out_valid, out_y, out_err
    );
endinterface

// File: rtl/mul5_chunk.sv
// Combinational digit step: p = 5*q_chunk + c split into a 4-bit output digit
// and a 3-bit carry into the next chunk.
module mul5_chunk
    import cdiv_pkg::*;
(
    input  logic [CHUNK_W-1:0] q_chunk_i,
    input  logic [CARRY_W-1:0] c_i,
    output logic [CHUNK_W-1:0] digit_o,
    output logic [CARRY_W-1:0] carry_o
);
    logic [CARRY_W+CHUNK_W-1:0] p;

    assign p                  = chunk_mac(q_chunk_i, c_i);
    assign {carry_o, digit_o} = p;
endmodule

// File: rtl/mul5_recon.sv
// Digit-serial reconstruction y = 5*q + r: one 4-bit chunk of q per cycle, LSB first,
// digits entering the result register from the top; final carry forms y[W+2:W].
module mul5_recon
    import cdiv_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 4,
    parameter int K  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mul5_recon_if.slave  bus
);
    localparam int NCH   = W / CW;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    // The chunk datapath is sized for the package constants only.
    if (CW != CHUNK_W || K != K_DIV || (W % CW) != 0) begin : g_bad_param
        $error("mul5_recon: unsupported W/CW/K combination");
    end

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       q_sh_q;
    logic [W-1:0]       res_q;
    logic [CARRY_W-1:0] c_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic               accept;
    logic               last;
    logic [CW-1:0]      digit;
    logic [CARRY_W-1:0] carry;

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign last   = (cnt_q == CNT_W'(NCH - 1));

    mul5_chunk u_chunk (
        .q_chunk_i (q_sh_q[CW-1:0]),
        .c_i       (c_q),
        .digit_o   (digit),
        .carry_o   (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they leave the block registered.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh_q <= '0;
            res_q  <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            q_sh_q <= bus.in_q;
            c_q    <= bus.in_r;
            cnt_q  <= '0;
            err_q  <= (bus.in_r >= 3'd5);
        end else if (state_q == RUN) begin
            q_sh_q <= q_sh_q >> CW;
            res_q  <= {digit, res_q[W-1:CW]};
            c_q    <= carry;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = {c_q, res_q};
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_mul5_recon.sv
// Self-checking bench for mul5_recon: directed vector table, backpressure, resets,
// back-to-back throughput and randomized transactions against an arithmetic model.
module tb_mul5_recon;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul5_recon_if #(.W(32)) bus ();

    mul5_recon #(.W(32), .CW(4), .K(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] q;
        logic [2:0]  r;
        logic [34:0] y;
        logic        e;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] model_y(input logic [31:0] q, input logic [2:0] r);
        return 35'(q) * 35'd5 + 35'(r);
    endfunction

    // Called just after a rising edge; returns just after the output handshake edge.
    task automatic run_txn(input logic [31:0] q, input logic [2:0] r, input int hold,
                           input logic [34:0] exp_y, input logic exp_e, output time t_acc);
        int          lat;
        bit          seen;
        logic [34:0] y0;
        bus.in_q      = q;
        bus.in_r      = r;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        t_acc = $time;
        #1;
        bus.in_valid = 1'b0;
        bus.in_q     = $urandom;
        bus.in_r     = 3'($urandom_range(0, 7));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("in_ready_run", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid not seen after %0d cycles, required 9", lat);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            return;
        end
        chk("latency", 64'(lat), 64'd9);
        chk("out_y", 64'(bus.out_y), 64'(exp_y));
        chk("out_err", 64'(bus.out_err), 64'(exp_e));
        y0 = bus.out_y;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_y", 64'(bus.out_y), 64'(y0));
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", 64'(bus.out_valid), 64'd0);
        chk("in_ready_back", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        time t0, t1, t2, t3;
        bit  spurious;

        tbl[0] = '{32'h0000_0000, 3'd0, 35'h0_0000_0000, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 3'd4, 35'h4_FFFF_FFFF, 1'b0};
        tbl[2] = '{32'h3333_3333, 3'd1, 35'h1_0000_0000, 1'b0};
        tbl[3] = '{32'h0000_0001, 3'd5, 35'h0_0000_000A, 1'b1};
        tbl[4] = '{32'h0000_0001, 3'd0, 35'h0_0000_0005, 1'b0};
        tbl[5] = '{32'h0000_0007, 3'd2, 35'h0_0000_0025, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 3'd7, 35'h5_0000_0002, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_q      = '0;
        bus.in_r      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid_after", 64'(bus.out_valid), 64'd0);
        chk("rst_out_y", 64'(bus.out_y), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].q, tbl[i].r, 0, tbl[i].y, tbl[i].e, t0);
        end

        // Backpressure in DONE, then three back-to-back transactions.
        run_txn(32'hDEAD_BEEF, 3'd3, 6, model_y(32'hDEAD_BEEF, 3'd3), 1'b0, t0);
        run_txn(32'h1234_5678, 3'd2, 0, model_y(32'h1234_5678, 3'd2), 1'b0, t1);
        run_txn(32'h8000_0000, 3'd4, 0, model_y(32'h8000_0000, 3'd4), 1'b0, t2);
        run_txn(32'h0F0F_0F0F, 3'd6, 0, model_y(32'h0F0F_0F0F, 3'd6), 1'b1, t3);
        chk("b2b_period_a", 64'(t2 - t1), 64'd100);
        chk("b2b_period_b", 64'(t3 - t2), 64'd100);

        // Reset while RUN is at cnt=4.
        bus.in_q     = 32'h1234_5678;
        bus.in_r     = 3'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("midrun_rst_y", 64'(bus.out_y), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) spurious = 1'b1;
        end
        chk("midrun_no_spurious", 64'(spurious), 64'd0);
        @(posedge clk);
        #1;
        run_txn(32'd7, 3'd2, 0, 35'd37, 1'b0, t0);

        // Reset while DONE is stalled.
        bus.in_q     = 32'h0000_00FF;
        bus.in_r     = 3'd6;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("done_before_rst", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("middone_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("middone_rst_err", 64'(bus.out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            logic [31:0] q;
            logic [2:0]  r;
            q = $urandom;
            r = 3'($urandom_range(0, 7));
            run_txn(q, r, $urandom_range(0, 3), model_y(q, r), (r >= 3'd5), t0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
